// File: rtl/icache_fill_fsm_pkg.sv
// Shared types and constants for the instruction-cache miss/fill controller.
// The block is 8 words of 16 bits (16 bytes), so the low 4 address bits
// select a byte within the block and bits [3:1] select the word.
package icache_fill_fsm_pkg;

    localparam int BLOCK_WORDS = 8;
    localparam int ADDR_W      = 16;
    localparam int DATA_W      = 16;
    localparam int OFFSET_W    = $clog2(BLOCK_WORDS);
    localparam int CNT_W       = OFFSET_W + 1;

    localparam logic [ADDR_W-1:0] BLOCK_MASK = 16'hFFF0;

    // Counter values for "all words issued/received" and "last word".
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BLOCK_WORDS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLOCK_WORDS - 1);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_GRANT = 2'd1,
        FILL       = 2'd2,
        DONE       = 2'd3
    } state_t;

    // Word address inside the block; the offset never carries into the tag
    // because the base has its low bits cleared and the offset is OR-ed in.
    function automatic logic [ADDR_W-1:0] word_address(
        input logic [ADDR_W-1:0]   base,
        input logic [OFFSET_W-1:0] word
    );
        return base | ADDR_W'({word, 1'b0});
    endfunction

endpackage

// File: rtl/icache_fill_fsm_if.sv
// Fetch-stage / memory-port / array-write signals of the I-cache fill
// controller. The master modport is the controller's view; the slave modport
// is the view of the surrounding fetch stage, arbiter, memory and arrays.
// Optional: ICACHE_MISS_COUNT_EN adds the miss_count statistic.
interface icache_fill_fsm_if;
    import icache_fill_fsm_pkg::*;

    logic                miss_detected;
    logic [ADDR_W-1:0]   miss_address;
    logic                mem_grant;
    logic [DATA_W-1:0]   memory_data_in;
    logic                memory_data_valid;
    logic                fsm_busy;
    logic                memory_request;
    logic [ADDR_W-1:0]   memory_address;
    logic                write_data_array;
    logic [OFFSET_W-1:0] write_word_offset;
    logic                write_tag_array;
    logic [ADDR_W-1:0]   fill_address;
`ifdef ICACHE_MISS_COUNT_EN
    logic [15:0]         miss_count;
`endif

    modport master (
        input  miss_detected,
        input  miss_address,
        input  mem_grant,
        input  memory_data_in,
        input  memory_data_valid,
`ifdef ICACHE_MISS_COUNT_EN
        output miss_count,
`endif
        output fsm_busy,
        output memory_request,
        output memory_address,
        output write_data_array,
        output write_word_offset,
        output write_tag_array,
        output fill_address
    );

    modport slave (
        output miss_detected,
        output miss_address,
        output mem_grant,
        output memory_data_in,
        output memory_data_valid,
`ifdef ICACHE_MISS_COUNT_EN
        input  miss_count,
`endif
        input  fsm_busy,
        input  memory_request,
        input  memory_address,
        input  write_data_array,
        input  write_word_offset,
        input  write_tag_array,
        input  fill_address
    );

endinterface

// File: rtl/icache_fill_counter.sv
// Small up-counter used for both the issue and the receive word counts of a
// block fill. Clear wins over enable so a new miss always starts from zero.
module icache_fill_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] count
);

    // Synchronous reset/clear, otherwise count one per enabled cycle.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/icache_fill_fsm.sv
// I-cache miss handler: latches the missing block, streams its eight words
// from the pipelined memory port, writes each returned word into the data
// array, then writes the tag/valid entry. Stalls fetch while active.
// Optional: ICACHE_MISS_COUNT_EN adds a saturating 16-bit miss counter.
//
// state      | meaning
// IDLE       | no fill in progress; a miss is accepted here
// WAIT_GRANT | requesting the memory port, no word issued yet
// FILL       | issuing remaining reads and writing returned words
// DONE       | one-cycle tag/valid write, then back to IDLE
module icache_fill_fsm
    import icache_fill_fsm_pkg::*;
(
    input logic               clk,
    input logic               rst,
    icache_fill_fsm_if.master bus
);

    state_t            state;
    logic [ADDR_W-1:0] base_q;
    logic [CNT_W-1:0]  issue_cnt;
    logic [CNT_W-1:0]  recv_cnt;

    logic miss_accept;
    logic issuing;
    logic issue_fire;
    logic recv_fire;

    assign miss_accept = (state == IDLE) && bus.miss_detected;

    // Reads are requested in both WAIT_GRANT and FILL until all words are out;
    // a lost grant just holds the counter, the state is unaffected.
    assign issuing    = ((state == WAIT_GRANT) || (state == FILL))
                        && (issue_cnt < CNT_FULL);
    assign issue_fire = issuing && bus.mem_grant;

    // Returns only count in FILL; anything arriving in IDLE is a stale word
    // from a fill that reset aborted.
    assign recv_fire  = (state == FILL) && bus.memory_data_valid
                        && (recv_cnt < CNT_FULL);

    icache_fill_counter #(.W(CNT_W)) u_issue_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (miss_accept),
        .en    (issue_fire),
        .count (issue_cnt)
    );

    icache_fill_counter #(.W(CNT_W)) u_recv_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (miss_accept),
        .en    (recv_fire),
        .count (recv_cnt)
    );

    // State register and block-base latch.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            base_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.miss_detected) begin
                        base_q <= bus.miss_address & BLOCK_MASK;
                        state  <= WAIT_GRANT;
                    end
                end
                WAIT_GRANT: begin
                    if (issue_fire) begin
                        state <= FILL;
                    end
                end
                FILL: begin
                    if (recv_fire && (recv_cnt == CNT_LAST)) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // The stall must already be visible in the miss cycle itself, hence the
    // direct term from miss_detected.
    assign bus.fsm_busy          = (state != IDLE) | bus.miss_detected;
    assign bus.memory_request    = issuing;
    assign bus.memory_address    = word_address(base_q, issue_cnt[OFFSET_W-1:0]);
    assign bus.write_data_array  = recv_fire;
    assign bus.write_word_offset = recv_cnt[OFFSET_W-1:0];
    assign bus.write_tag_array   = (state == DONE);
    assign bus.fill_address      = base_q;

`ifdef ICACHE_MISS_COUNT_EN
    logic [15:0] miss_cnt_q;

    // Count accepted misses, sticking at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            miss_cnt_q <= '0;
        end else if (miss_accept && (miss_cnt_q != 16'hFFFF)) begin
            miss_cnt_q <= miss_cnt_q + 16'd1;
        end
    end

    assign bus.miss_count = miss_cnt_q;
`endif

endmodule

// File: tb/tb_icache_fill_fsm.sv
// Directed bench for icache_fill_fsm with a 4-cycle pipelined memory model.
// Memory returns the issued address as data so return order is visible.
module tb_icache_fill_fsm;

    logic clk = 1'b0;
    logic rst;
    logic spur = 1'b0;

    always #5 clk = ~clk;

    icache_fill_fsm_if bus();

    icache_fill_fsm dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_vec = 0;
    int n_err = 0;
    int n_w, n_t, n_r, n_b;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Fixed-latency memory: a word issued in cycle n returns in cycle n+4.
    initial begin
        logic        pv [4];
        logic [15:0] pd [4];
        logic        iss;
        logic [15:0] ia;
        for (int i = 0; i < 4; i++) begin
            pv[i] = 1'b0;
            pd[i] = '0;
        end
        bus.memory_data_valid = 1'b0;
        bus.memory_data_in    = '0;
        forever begin
            @(negedge clk);
            iss = bus.memory_request & bus.mem_grant;
            ia  = bus.memory_address;
            @(posedge clk);
            #2;
            for (int i = 3; i > 0; i--) begin
                pv[i] = pv[i-1];
                pd[i] = pd[i-1];
            end
            pv[0] = iss;
            pd[0] = ia;
            bus.memory_data_valid = pv[3] | spur;
            bus.memory_data_in    = pd[3];
        end
    end

    // One complete fill; called at posedge+1, cycle 0 is the miss cycle.
    task automatic run_fill(
        input string       nm,
        input logic [15:0] addr,
        input logic [15:0] exp_base,
        input int          gap_lo,
        input int          gap_hi,
        input int          exp_tag,
        input bit          late_miss
    );
        int n_iss = 0, n_wr = 0, n_tag = 0;
        int first_iss = -1, first_wr = -1, tag_cyc = -1, rel_cyc = -1;
        bus.miss_detected = 1'b1;
        bus.miss_address  = addr;
        bus.mem_grant     = 1'b1;
        @(negedge clk);
        chk({nm, "_busy_in_miss_cycle"}, 32'(bus.fsm_busy), 32'd1);
        chk({nm, "_no_req_in_miss_cycle"}, 32'(bus.memory_request), 32'd0);
        @(posedge clk);
        #1;
        bus.miss_detected = 1'b0;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            bus.mem_grant = !(cyc >= gap_lo && cyc <= gap_hi);
            if (late_miss && cyc == 6) begin
                bus.miss_detected = 1'b1;
                bus.miss_address  = 16'h4000;
            end else if (late_miss && cyc == 7) begin
                bus.miss_detected = 1'b0;
            end
            @(negedge clk);
            if (bus.memory_request && bus.mem_grant) begin
                if (first_iss < 0) first_iss = cyc;
                chk({nm, "_issue_addr"}, 32'(bus.memory_address),
                    32'(exp_base + 16'(2 * n_iss)));
                n_iss++;
            end
            if (bus.write_data_array) begin
                if (first_wr < 0) first_wr = cyc;
                chk({nm, "_write_offset"}, 32'(bus.write_word_offset), 32'(n_wr));
                chk({nm, "_write_data"}, 32'(bus.memory_data_in),
                    32'(exp_base + 16'(2 * n_wr)));
                n_wr++;
            end
            if (bus.write_tag_array) begin
                tag_cyc = cyc;
                n_tag++;
                chk({nm, "_fill_address"}, 32'(bus.fill_address), 32'(exp_base));
            end
            if (!bus.fsm_busy) begin
                rel_cyc = cyc;
                break;
            end
            @(posedge clk);
            #1;
        end
        chk({nm, "_issue_count"}, 32'(n_iss), 32'd8);
        chk({nm, "_write_count"}, 32'(n_wr), 32'd8);
        chk({nm, "_tag_count"}, 32'(n_tag), 32'd1);
        chk({nm, "_first_issue_cycle"}, 32'(first_iss), 32'd1);
        chk({nm, "_first_write_cycle"}, 32'(first_wr), 32'd5);
        chk({nm, "_tag_cycle"}, 32'(tag_cyc), 32'(exp_tag));
        chk({nm, "_release_cycle"}, 32'(rel_cyc), 32'(exp_tag + 1));
        chk({nm, "_fill_address_held"}, 32'(bus.fill_address), 32'(exp_base));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got still running want finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst               = 1'b1;
        bus.miss_detected = 1'b0;
        bus.miss_address  = '0;
        bus.mem_grant     = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 32'(bus.fsm_busy), 32'd0);
        chk("rst_req", 32'(bus.memory_request), 32'd0);
        chk("rst_addr", 32'(bus.memory_address), 32'd0);
        chk("rst_wda", 32'(bus.write_data_array), 32'd0);
        chk("rst_off", 32'(bus.write_word_offset), 32'd0);
        chk("rst_wta", 32'(bus.write_tag_array), 32'd0);
        chk("rst_fill_addr", 32'(bus.fill_address), 32'd0);
`ifdef ICACHE_MISS_COUNT_EN
        chk("rst_miss_count", 32'(bus.miss_count), 32'd0);
`endif

        // Reset held for two cycles while a miss is presented.
        @(posedge clk);
        #1;
        bus.miss_detected = 1'b1;
        bus.miss_address  = 16'h7777;
        repeat (2) begin
            @(negedge clk);
            chk("rst_miss_req", 32'(bus.memory_request), 32'd0);
            chk("rst_miss_busy", 32'(bus.fsm_busy), 32'd1);
            @(posedge clk);
            #1;
        end
        rst               = 1'b0;
        bus.miss_detected = 1'b0;
        @(negedge clk);
        chk("after_rst_req", 32'(bus.memory_request), 32'd0);
        chk("after_rst_busy", 32'(bus.fsm_busy), 32'd0);
        chk("after_rst_fill_addr", 32'(bus.fill_address), 32'd0);
        @(posedge clk);
        #1;

        run_fill("basic", 16'h1236, 16'h1230, 100, 0, 13, 1'b0);

        // Spurious returns while idle.
        spur = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("idle_valid_wda", 32'(bus.write_data_array), 32'd0);
            chk("idle_valid_wta", 32'(bus.write_tag_array), 32'd0);
            chk("idle_valid_busy", 32'(bus.fsm_busy), 32'd0);
            @(posedge clk);
            #1;
        end
        spur = 1'b0;
        @(posedge clk);
        #1;

        run_fill("grant_gap", 16'h1236, 16'h1230, 3, 5, 16, 1'b0);
        run_fill("late_miss", 16'h1236, 16'h1230, 100, 0, 13, 1'b1);

`ifdef ICACHE_MISS_COUNT_EN
        @(negedge clk);
        chk("miss_count_3", 32'(bus.miss_count), 32'd3);
        @(posedge clk);
        #1;
`endif

        // Reset after the third return, then stale returns.
        bus.miss_detected = 1'b1;
        bus.miss_address  = 16'h2468;
        bus.mem_grant     = 1'b1;
        @(posedge clk);
        #1;
        bus.miss_detected = 1'b0;
        n_w = 0;
        for (int cyc = 1; cyc <= 7; cyc++) begin
            if (cyc == 7) rst = 1'b1;
            @(negedge clk);
            if (bus.write_data_array) n_w++;
            @(posedge clk);
            #1;
        end
        chk("abort_writes_before_rst", 32'(n_w), 32'd3);
        rst  = 1'b0;
        spur = 1'b1;
        n_w = 0; n_t = 0; n_r = 0; n_b = 0;
        for (int cyc = 8; cyc <= 15; cyc++) begin
            if (cyc == 13) spur = 1'b0;
            @(negedge clk);
            if (bus.write_data_array) n_w++;
            if (bus.write_tag_array) n_t++;
            if (bus.memory_request) n_r++;
            if (bus.fsm_busy) n_b++;
            @(posedge clk);
            #1;
        end
        chk("abort_stale_writes", 32'(n_w), 32'd0);
        chk("abort_tag_writes", 32'(n_t), 32'd0);
        chk("abort_requests", 32'(n_r), 32'd0);
        chk("abort_busy_cycles", 32'(n_b), 32'd0);

        run_fill("refill", 16'h5A5F, 16'h5A50, 100, 0, 13, 1'b0);

`ifdef ICACHE_MISS_COUNT_EN
        @(negedge clk);
        chk("miss_count_after_rst", 32'(bus.miss_count), 32'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
